// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives {x,y,z} through 000..111 into a downstream
// 3-input combinational block, samples f for each vector after a settle
// time, and compares the captured truth table against EXPECTED.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out,
  output logic [3:0] err_cnt
);

  // Settle counter must hold 0..SETTLE_CYCLES-1; keep at least one bit.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [2:0]      idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic [7:0]      tbl_reg;
  logic [7:0]      tbl_next;
  logic [3:0]      err_next;
  logic            sample_now;

  // The vector index is a register, so the drive to the downstream block is glitch-free.
  assign {x, y, z} = idx_reg;

  assign sample_now = (cnt_reg == CNT_LAST);

  // Table with the current sample folded in, so the final row is visible
  // to the result registers on the same edge it is captured.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fold
      assign tbl_next[gi] = (idx_reg == 3'(gi)) ? f : tbl_reg[gi];
    end
  endgenerate

  // Mismatch count of the folded table against the expected pattern.
  always_comb begin
    err_next = 4'd0;
    for (int i = 0; i < 8; i++) begin
      err_next = err_next + {3'd0, tbl_next[i] ^ EXPECTED[i]};
    end
  end

  // Sweep controller with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      cnt_reg   <= '0;
      tbl_reg   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= 8'd0;
      err_cnt   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          // abort beats start when both arrive together
          if (start && !abort) begin
            state_reg <= DRIVE;
            idx_reg   <= 3'd0;
            cnt_reg   <= '0;
            tbl_reg   <= 8'd0;
            busy      <= 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            // Drop the partial sweep; previous results stay on the outputs.
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else if (sample_now) begin
            tbl_reg <= tbl_next;
            cnt_reg <= '0;
            if (idx_reg == 3'd7) begin
              state_reg <= DONE;
              idx_reg   <= 3'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
              table_out <= tbl_next;
              pass      <= (tbl_next == EXPECTED);
              err_cnt   <= err_next;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          // Single-cycle completion pulse; start and abort are ignored here.
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with the default settle time
// and one with a single settle cycle, each fed by a bench-side function block.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0 -> settle 2 instance, index 1 -> settle 1 instance
  logic       start_r [2];
  logic       abort_r [2];
  int         mode_r  [2];   // 0: table lookup, 1: (x|y)&(~y|z), 2: ~x
  logic [7:0] src_r   [2];

  logic x2, y2, z2, busy2, done2, pass2, f2;
  logic x1, y1, z1, busy1, done1, pass1, f1;
  logic [7:0] tbl2, tbl1;
  logic [3:0] err2, err1;

  function automatic logic fn(int mode, logic [7:0] src, logic x, logic y, logic z);
    case (mode)
      1:       return (x | y) & (~y | z);
      2:       return ~x;
      default: return src[{x, y, z}];
    endcase
  endfunction

  assign f2 = fn(mode_r[0], src_r[0], x2, y2, z2);
  assign f1 = fn(mode_r[1], src_r[1], x1, y1, z1);

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'hB8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]), .f(f2),
    .x(x2), .y(y2), .z(z2), .busy(busy2), .done(done2), .pass(pass2),
    .table_out(tbl2), .err_cnt(err2)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hB8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]), .f(f1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(tbl1), .err_cnt(err1)
  );

  int checks = 0;
  int errors = 0;

  // model of the last completed sweep per instance
  logic [7:0] m_tbl  [2];
  logic [3:0] m_err  [2];
  logic       m_pass [2];

  function automatic logic [2:0] cur_xyz(int sel);
    return sel ? {x1, y1, z1} : {x2, y2, z2};
  endfunction
  function automatic logic cur_busy(int sel); return sel ? busy1 : busy2; endfunction
  function automatic logic cur_done(int sel); return sel ? done1 : done2; endfunction
  function automatic logic cur_pass(int sel); return sel ? pass1 : pass2; endfunction
  function automatic logic [7:0] cur_tbl(int sel); return sel ? tbl1 : tbl2; endfunction
  function automatic logic [3:0] cur_err(int sel); return sel ? err1 : err2; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Run a full sweep on instance sel and check sequence, latency and results.
  // inj_start re-asserts start mid-sweep and in the DONE cycle.
  task automatic do_sweep(input int sel, input int mode, input logic [7:0] src,
                          input logic [7:0] e_tbl, input logic [3:0] e_err,
                          input logic e_pass, input bit inj_start, input string name);
    int  s;
    bit  seq_ok;
    s = sel ? 1 : 2;
    mode_r[sel] = mode;
    src_r[sel]  = src;
    @(negedge clk);
    start_r[sel] = 1'b1;
    @(posedge clk); #1;
    start_r[sel] = 1'b0;
    seq_ok = 1'b1;
    for (int e = 1; e <= 8 * s; e++) begin
      if (cur_xyz(sel) !== 3'((e - 1) / s) || cur_busy(sel) !== 1'b1 || cur_done(sel) !== 1'b0)
        seq_ok = 1'b0;
      if (inj_start) start_r[sel] = (e == 5);
      @(posedge clk); #1;
    end
    start_r[sel] = 1'b0;
    chk({name, " xyz_seq"}, 32'(seq_ok), 32'd1);
    chk({name, " done_latency"}, 32'(cur_done(sel)), 32'd1);
    chk({name, " busy_in_done"}, 32'(cur_busy(sel)), 32'd0);
    chk({name, " table_out"}, 32'(cur_tbl(sel)), 32'(e_tbl));
    chk({name, " err_cnt"}, 32'(cur_err(sel)), 32'(e_err));
    chk({name, " pass"}, 32'(cur_pass(sel)), 32'(e_pass));
    if (inj_start) start_r[sel] = 1'b1;
    @(posedge clk); #1;
    start_r[sel] = 1'b0;
    chk({name, " done_single"}, 32'(cur_done(sel)), 32'd0);
    if (inj_start) chk({name, " start_in_done_ignored"}, 32'(cur_busy(sel)), 32'd0);
    m_tbl[sel]  = e_tbl;
    m_err[sel]  = e_err;
    m_pass[sel] = e_pass;
  endtask

  typedef struct {
    int         sel;
    int         mode;
    logic [7:0] src;
    logic [7:0] tbl;
    logic [3:0] err;
    logic       pss;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit         saw_done;
    logic [7:0] r;

    vecs[0] = '{0, 1, 8'h00, 8'hB8, 4'd0, 1'b1};
    vecs[1] = '{0, 0, 8'h00, 8'h00, 4'd4, 1'b0};
    vecs[2] = '{0, 0, 8'hFF, 8'hFF, 4'd4, 1'b0};
    vecs[3] = '{1, 2, 8'h00, 8'h0F, 4'd6, 1'b0};
    vecs[4] = '{1, 0, 8'h47, 8'h47, 4'd8, 1'b0};
    vecs[5] = '{0, 0, 8'hB9, 8'hB9, 4'd1, 1'b0};
    vecs[6] = '{1, 1, 8'h00, 8'hB8, 4'd0, 1'b1};
    vecs[7] = '{0, 0, 8'h5A, 8'h5A, 4'd4, 1'b0};

    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; abort_r[i] = 1'b0; mode_r[i] = 0; src_r[i] = 8'h00;
      m_tbl[i] = 8'h00; m_err[i] = 4'd0; m_pass[i] = 1'b0;
    end

    // reset state
    #12;
    chk("reset busy", 32'(busy2), 32'd0);
    chk("reset done", 32'(done2), 32'd0);
    chk("reset outputs", {13'd0, x2, y2, z2, pass2, tbl2, err2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle after reset", {28'd0, busy2, busy1, done2, done1}, 32'd0);

    // table-driven sweeps
    for (int i = 0; i < 8; i++)
      do_sweep(vecs[i].sel, vecs[i].mode, vecs[i].src, vecs[i].tbl, vecs[i].err,
               vecs[i].pss, 1'b0, $sformatf("vec%0d", i));

    // start re-asserted during DRIVE and in DONE
    do_sweep(0, 1, 8'h00, 8'hB8, 4'd0, 1'b1, 1'b1, "restart_ignored");

    // abort at idx=5 keeps previous results
    mode_r[0] = 0; src_r[0] = 8'h00;
    @(negedge clk); start_r[0] = 1'b1;
    @(posedge clk); #1; start_r[0] = 1'b0;
    for (int e = 1; e < 11; e++) begin @(posedge clk); #1; end
    chk("abort at idx5", 32'(cur_xyz(0)), 32'd5);
    abort_r[0] = 1'b1;
    @(posedge clk); #1; abort_r[0] = 1'b0;
    chk("abort busy", 32'(busy2), 32'd0);
    chk("abort xyz", 32'({x2, y2, z2}), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done2) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    chk("abort keeps table", 32'(tbl2), 32'(m_tbl[0]));
    chk("abort keeps pass", 32'(pass2), 32'(m_pass[0]));
    chk("abort keeps err", 32'(err2), 32'(m_err[0]));
    do_sweep(0, 0, 8'h00, 8'h00, 4'd4, 1'b0, 1'b0, "after_abort");

    // start and abort together in IDLE
    @(negedge clk); start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(posedge clk); #1; start_r[0] = 1'b0; abort_r[0] = 1'b0;
    chk("start+abort idle busy", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    chk("start+abort idle xyz", 32'({x2, y2, z2, done2}), 32'd0);

    // randomized sweeps against the model
    for (int k = 0; k < 6; k++) begin
      int sel;
      sel = $urandom_range(1, 0);
      r = 8'($urandom);
      do_sweep(sel, 0, r, r, 4'($countones(r ^ 8'hB8)), (r == 8'hB8), 1'b0,
               $sformatf("rand%0d", k));
    end

    // reset mid-sweep, after a sweep that leaves non-zero results
    do_sweep(0, 1, 8'h00, 8'hB8, 4'd0, 1'b1, 1'b0, "pre_reset");
    mode_r[0] = 0; src_r[0] = 8'hFF;
    @(negedge clk); start_r[0] = 1'b1;
    @(posedge clk); #1; start_r[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("midsweep reset busy", 32'(busy2), 32'd0);
    chk("midsweep reset outputs", {13'd0, x2, y2, z2, pass2, tbl2, err2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle after midsweep reset", {28'd0, busy2, done2, pass2, x2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
